// File: rtl/index_seq_pkg.sv
// Shared widths and state encoding for the index up-sequencer.
package index_seq_pkg;
    localparam int OC_W = 4;
    localparam int KH_W = 3;
    localparam int KW_W = 3;
    localparam int FL_W = OC_W + KH_W + KW_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;
endpackage

// File: rtl/index_wrap_counter.sv
// Single loop index: counts up on inc, wraps to 0 after reaching bound-1.
// o_wrap flags the terminal value so the next-outer loop can carry.
module index_wrap_counter #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [W-1:0] i_bound,
    input  logic         i_inc,
    input  logic         i_clear,
    output logic [W-1:0] o_idx,
    output logic         o_wrap
);
    logic [W-1:0] r_idx;

    assign o_idx  = r_idx;
    assign o_wrap = (r_idx == i_bound - W'(1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)     r_idx <= '0;
        else if (i_clear) r_idx <= '0;
        else if (i_inc)   r_idx <= o_wrap ? '0 : r_idx + W'(1);
    end
endmodule

// File: rtl/index_up_sequencer.sv
// Emits (oc, kh, kw) tuples in nested order over a valid/ready stream.
// Optional stall counter port enabled by defining INDEX_SEQ_STALL_CNT_EN.
module index_up_sequencer
    import index_seq_pkg::*;
(
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    input  logic [OC_W-1:0] oc_bound,
    input  logic [KH_W-1:0] kh_bound,
    input  logic [KW_W-1:0] kw_bound,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OC_W-1:0] oc_idx,
    output logic [KH_W-1:0] kh_idx,
    output logic [KW_W-1:0] kw_idx,
    output logic [FL_W-1:0] flat_idx,
    output logic            last,
    output logic            busy,
    output logic            done
`ifdef INDEX_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]     stall_cnt
`endif
);
    seq_state_e      r_state;
    logic [OC_W-1:0] r_oc_b;
    logic [KH_W-1:0] r_kh_b;
    logic [KW_W-1:0] r_kw_b;
    logic [FL_W-1:0] r_flat;
    logic            w_start_acc, w_empty, w_hs;
    logic            w_kw_wrap, w_kh_wrap, w_oc_wrap;

    assign w_start_acc = (r_state == IDLE) && start;
    assign w_empty     = (oc_bound == '0) || (kh_bound == '0) || (kw_bound == '0);
    assign w_hs        = (r_state == RUN) && out_ready;

    assign out_valid = (r_state == RUN);
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign flat_idx  = r_flat;
    assign last      = (r_state == RUN) && w_oc_wrap && w_kh_wrap && w_kw_wrap;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    if (start) r_state <= w_empty ? DONE : RUN;
                RUN:     if (out_ready && last) r_state <= DONE;
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Bounds are captured only on an accepted start; later input changes are ignored.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_oc_b <= '0;
            r_kh_b <= '0;
            r_kw_b <= '0;
        end else if (w_start_acc) begin
            r_oc_b <= oc_bound;
            r_kh_b <= kh_bound;
            r_kw_b <= kw_bound;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)         r_flat <= '0;
        else if (w_start_acc) r_flat <= '0;
        else if (w_hs)        r_flat <= r_flat + FL_W'(1);
    end

    index_wrap_counter #(.W(KW_W)) u_kw (
        .clock(clock), .reset_n(reset_n), .i_bound(r_kw_b),
        .i_inc(w_hs), .i_clear(w_start_acc), .o_idx(kw_idx), .o_wrap(w_kw_wrap)
    );
    index_wrap_counter #(.W(KH_W)) u_kh (
        .clock(clock), .reset_n(reset_n), .i_bound(r_kh_b),
        .i_inc(w_hs && w_kw_wrap), .i_clear(w_start_acc), .o_idx(kh_idx), .o_wrap(w_kh_wrap)
    );
    index_wrap_counter #(.W(OC_W)) u_oc (
        .clock(clock), .reset_n(reset_n), .i_bound(r_oc_b),
        .i_inc(w_hs && w_kw_wrap && w_kh_wrap), .i_clear(w_start_acc),
        .o_idx(oc_idx), .o_wrap(w_oc_wrap)
    );

`ifdef INDEX_SEQ_STALL_CNT_EN
    logic [15:0] r_stall;
    assign stall_cnt = r_stall;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_stall <= '0;
        else if (w_start_acc)
            r_stall <= '0;
        else if ((r_state == RUN) && !out_ready && (r_stall != 16'hFFFF))
            r_stall <= r_stall + 16'd1;
    end
`endif
endmodule

// File: tb/tb_index_up_sequencer.sv
// Self-checking bench: directed scenarios plus random bounds/ready against a nested-loop tuple model.
module tb_index_up_sequencer;
    import index_seq_pkg::*;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic            start = 1'b0;
    logic [OC_W-1:0] oc_bound = '0;
    logic [KH_W-1:0] kh_bound = '0;
    logic [KW_W-1:0] kw_bound = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [OC_W-1:0] oc_idx;
    logic [KH_W-1:0] kh_idx;
    logic [KW_W-1:0] kw_idx;
    logic [FL_W-1:0] flat_idx;
    logic            last, busy, done;
`ifdef INDEX_SEQ_STALL_CNT_EN
    logic [15:0]     stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct { int oc; int kh; int kw; } tup_t;

    index_up_sequencer dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .oc_bound(oc_bound), .kh_bound(kh_bound), .kw_bound(kw_bound),
        .out_valid(out_valid), .out_ready(out_ready),
        .oc_idx(oc_idx), .kh_idx(kh_idx), .kw_idx(kw_idx),
        .flat_idx(flat_idx), .last(last), .busy(busy), .done(done)
`ifdef INDEX_SEQ_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: ready always 1, mode 1: ready 1010..., mode 2: random ready
    task automatic run_seq(input int ob, input int hb, input int wb, input int mode, input bit inject);
        tup_t q[$];
        int   beat = 0;
        int   cyc = 0;
        int   nstall = 0;
        bit   rdy;
        for (int o = 0; o < ob; o++)
            for (int h = 0; h < hb; h++)
                for (int w = 0; w < wb; w++)
                    q.push_back('{o, h, w});
        @(negedge clock);
        oc_bound = OC_W'(ob); kh_bound = KH_W'(hb); kw_bound = KW_W'(wb);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        while (q.size() > 0 && cyc < 2000) begin
            check("valid", 32'(out_valid), 1);
            check("busy_run", 32'(busy), 1);
            check("done_run", 32'(done), 0);
            check("oc_idx", 32'(oc_idx), q[0].oc);
            check("kh_idx", 32'(kh_idx), q[0].kh);
            check("kw_idx", 32'(kw_idx), q[0].kw);
            check("flat_idx", 32'(flat_idx), beat);
            check("last", 32'(last), (q.size() == 1) ? 1 : 0);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            if (!rdy) nstall++;
            if (inject && cyc == 1) begin
                start = 1'b1;
                oc_bound = OC_W'(ob + 1); kh_bound = KH_W'(hb + 1); kw_bound = KW_W'(wb + 1);
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            cyc++;
            if (rdy) begin
                void'(q.pop_front());
                beat++;
            end
        end
        start = 1'b0;
        out_ready = 1'b0;
        check("seq_remaining", 32'(q.size()), 0);
        check("valid_done", 32'(out_valid), 0);
        check("done_pulse", 32'(done), 1);
        check("busy_done", 32'(busy), 1);
        @(negedge clock);
        check("done_clear", 32'(done), 0);
        check("busy_idle", 32'(busy), 0);
        check("valid_idle", 32'(out_valid), 0);
`ifdef INDEX_SEQ_STALL_CNT_EN
        check("stall_cnt", 32'(stall_cnt), nstall);
`endif
    endtask

    initial begin
        // reset state
        #2;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_flat", 32'(flat_idx), 0);
        check("rst_tuple", {oc_idx, kh_idx, kw_idx}, 0);
        @(negedge clock);
        reset_n = 1'b1;

        run_seq(2, 2, 3, 0, 1'b0);
        run_seq(1, 1, 1, 0, 1'b0);
        run_seq(2, 0, 3, 0, 1'b0);
        run_seq(2, 1, 2, 1, 1'b0);
        run_seq(2, 2, 2, 0, 1'b1);

        // reset after 5 of 12 beats
        @(negedge clock);
        oc_bound = 2; kh_bound = 2; kw_bound = 3; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        out_ready = 1'b1;
        for (int b = 0; b < 5; b++) begin
            check("mid_kw", 32'(kw_idx), b % 3);
            check("mid_kh", 32'(kh_idx), (b / 3) % 2);
            check("mid_oc", 32'(oc_idx), b / 6);
            @(negedge clock);
        end
        reset_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_done", 32'(done), 0);
        check("arst_flat", 32'(flat_idx), 0);
        out_ready = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("post_rst_done", 32'(done), 0);
        check("post_rst_busy", 32'(busy), 0);
        run_seq(2, 2, 3, 0, 1'b0);

        for (int t = 0; t < 12; t++)
            run_seq($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 2), 1'($urandom_range(0, 1)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
